// File: rtl/uart_pkg.sv
// Shared types and byte constants for the UART bus host and its TX serializer.
package uart_pkg;

  typedef enum logic [1:0] {S_IDLE, S_START, S_PROC, S_STOP} ser_state_e;

  typedef enum logic [2:0] {
    P_IDLE, P_ADDR, P_DATA, P_BUS_REQ, P_BUS_WAIT, P_RESP
  } parse_state_e;

  localparam logic [7:0] OP_WRITE = 8'h57;
  localparam logic [7:0] OP_READ  = 8'h52;
  localparam logic [7:0] RESP_ACK = 8'h4B;

endpackage

// File: rtl/uart_byte_tx.sv
// 8N1 byte serializer; ready rises in the last stop-bit cycle so queued bytes go out back-to-back.
module uart_byte_tx
  import uart_pkg::*;
#(
  parameter int ClocksPerBaud = 434
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [7:0] data_i,
  input  logic       valid_i,
  output logic       ready_o,
  output logic       tx_o
);

  localparam int CntW = (ClocksPerBaud > 1) ? $clog2(ClocksPerBaud) : 1;
  localparam logic [CntW-1:0] BaudLast = CntW'(ClocksPerBaud - 1);

  ser_state_e      r_state;
  logic [CntW-1:0] r_cnt;
  logic [2:0]      r_bit;
  logic [7:0]      r_shift;
  logic            r_tx;
  logic            w_bit_end;
  logic            w_load;

  assign w_bit_end = (r_cnt == BaudLast);
  assign ready_o   = (r_state == S_IDLE) || ((r_state == S_STOP) && w_bit_end);
  assign w_load    = valid_i && ready_o;
  assign tx_o      = r_tx;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_tx    <= 1'b1;
    end else if (w_load) begin
      r_state <= S_START;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_shift <= data_i;
      r_tx    <= 1'b0;
    end else if (r_state != S_IDLE) begin
      r_cnt <= w_bit_end ? '0 : r_cnt + 1'b1;
      if (w_bit_end) begin
        case (r_state)
          S_START: begin
            r_state <= S_PROC;
            r_tx    <= r_shift[0];
          end
          S_PROC: begin
            r_bit   <= r_bit + 1'b1;
            r_shift <= {1'b0, r_shift[7:1]};
            if (r_bit == 3'd7) begin
              r_state <= S_STOP;
              r_tx    <= 1'b1;
            end else begin
              r_tx <= r_shift[1];
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: rtl/uart_bus_host.sv
// UART command bridge: parses W/R frames from the RX line, runs one bus access, answers on TX.
// Parser states:  P_IDLE wait opcode | P_ADDR 4 addr bytes | P_DATA 4 data bytes |
//                 P_BUS_REQ req held until gnt | P_BUS_WAIT wait rvalid | P_RESP feed reply bytes to TX
module uart_bus_host
  import uart_pkg::*;
#(
  parameter int ClockFrequency = 50_000_000,
  parameter int BaudRate       = 115_200,
  parameter int AddrWidth      = 32,
  parameter int DataWidth      = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 uart_rx_i,
  output logic                 uart_tx_o,
  output logic                 host_req_o,
  input  logic                 host_gnt_i,
  output logic [AddrWidth-1:0] host_addr_o,
  output logic                 host_we_o,
  output logic [3:0]           host_be_o,
  output logic [DataWidth-1:0] host_wdata_o,
  input  logic                 host_rvalid_i,
  input  logic [DataWidth-1:0] host_rdata_i,
  output logic                 busy_o,
  output logic                 frame_err_o
);

  localparam int ClocksPerBaud = ClockFrequency / BaudRate;
  localparam int CntW = (ClocksPerBaud > 1) ? $clog2(ClocksPerBaud) : 1;
  localparam logic [CntW-1:0] BaudLast = CntW'(ClocksPerBaud - 1);
  localparam logic [CntW-1:0] BaudHalf = CntW'(ClocksPerBaud / 2);

  logic [2:0]      r_rx_sync;
  logic            r_rx_prev;
  ser_state_e      r_rx_state;
  logic [CntW-1:0] r_rx_cnt;
  logic [2:0]      r_rx_bit;
  logic [7:0]      r_rx_shift;
  logic            r_byte_valid;
  logic            r_frame_err;
  logic            w_rx;

  parse_state_e         r_state;
  logic [1:0]           r_byte_cnt;
  logic [DataWidth-1:0] r_rdata;
  logic                 w_tx_valid;
  logic                 w_tx_ready;
  logic [7:0]           w_tx_data;

  assign w_rx        = r_rx_sync[2];
  assign host_be_o   = 4'hF;
  assign busy_o      = (r_state != P_IDLE);
  assign frame_err_o = r_frame_err;
  assign w_tx_valid  = (r_state == P_RESP);
  assign w_tx_data   = host_we_o ? RESP_ACK : r_rdata[{r_byte_cnt, 3'b000} +: 8];

  // Down-counter reloads every bit; the half-bit preload centres all samples.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rx_sync    <= 3'b111;
      r_rx_prev    <= 1'b1;
      r_rx_state   <= S_IDLE;
      r_rx_cnt     <= '0;
      r_rx_bit     <= '0;
      r_rx_shift   <= '0;
      r_byte_valid <= 1'b0;
      r_frame_err  <= 1'b0;
    end else begin
      r_rx_sync    <= {r_rx_sync[1:0], uart_rx_i};
      r_rx_prev    <= w_rx;
      r_byte_valid <= 1'b0;
      r_frame_err  <= 1'b0;
      if (r_rx_state != S_IDLE) r_rx_cnt <= (r_rx_cnt == '0) ? BaudLast : r_rx_cnt - 1'b1;
      case (r_rx_state)
        S_IDLE: if (r_rx_prev && !w_rx) begin
          r_rx_state <= S_START;
          r_rx_cnt   <= BaudHalf;
        end
        S_START: if (r_rx_cnt == '0) begin
          r_rx_bit   <= '0;
          r_rx_state <= w_rx ? S_IDLE : S_PROC;
        end
        S_PROC: if (r_rx_cnt == '0) begin
          r_rx_shift <= {w_rx, r_rx_shift[7:1]};
          r_rx_bit   <= r_rx_bit + 1'b1;
          if (r_rx_bit == 3'd7) r_rx_state <= S_STOP;
        end
        default: if (r_rx_cnt == '0) begin
          r_byte_valid <= w_rx;
          r_frame_err  <= !w_rx;
          r_rx_state   <= S_IDLE;
        end
      endcase
    end
  end

  // A framing error only aborts command collection; a bus access already in flight completes.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state      <= P_IDLE;
      r_byte_cnt   <= '0;
      r_rdata      <= '0;
      host_req_o   <= 1'b0;
      host_we_o    <= 1'b0;
      host_addr_o  <= '0;
      host_wdata_o <= '0;
    end else if (r_frame_err && (r_state inside {P_IDLE, P_ADDR, P_DATA})) begin
      r_state    <= P_IDLE;
      r_byte_cnt <= '0;
    end else begin
      case (r_state)
        P_IDLE: if (r_byte_valid && (r_rx_shift == OP_WRITE || r_rx_shift == OP_READ)) begin
          host_we_o  <= (r_rx_shift == OP_WRITE);
          r_byte_cnt <= '0;
          r_state    <= P_ADDR;
        end
        P_ADDR: if (r_byte_valid) begin
          host_addr_o[{r_byte_cnt, 3'b000} +: 8] <= r_rx_shift;
          r_byte_cnt <= r_byte_cnt + 1'b1;
          if (r_byte_cnt == 2'd3) begin
            r_state    <= host_we_o ? P_DATA : P_BUS_REQ;
            host_req_o <= !host_we_o;
          end
        end
        P_DATA: if (r_byte_valid) begin
          host_wdata_o[{r_byte_cnt, 3'b000} +: 8] <= r_rx_shift;
          r_byte_cnt <= r_byte_cnt + 1'b1;
          if (r_byte_cnt == 2'd3) begin
            r_state    <= P_BUS_REQ;
            host_req_o <= 1'b1;
          end
        end
        P_BUS_REQ: if (host_gnt_i) begin
          host_req_o <= 1'b0;
          r_state    <= P_BUS_WAIT;
        end
        P_BUS_WAIT: if (host_rvalid_i) begin
          r_rdata    <= host_rdata_i;
          r_byte_cnt <= '0;
          r_state    <= P_RESP;
        end
        P_RESP: if (w_tx_ready) begin
          r_byte_cnt <= r_byte_cnt + 1'b1;
          if (host_we_o || r_byte_cnt == 2'd3) r_state <= P_IDLE;
        end
        default: r_state <= P_IDLE;
      endcase
    end
  end

  uart_byte_tx #(
    .ClocksPerBaud(ClocksPerBaud)
  ) u_tx (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .data_i (w_tx_data),
    .valid_i(w_tx_valid),
    .ready_o(w_tx_ready),
    .tx_o   (uart_tx_o)
  );

endmodule

// File: tb/tb_uart_bus_host.sv
// Directed plus randomized bench for uart_bus_host: serial command driver, bus responder, TX decoder.
module tb_uart_bus_host;

  localparam int CF  = 1_000_000;
  localparam int BR  = 100_000;
  localparam int CPB = CF / BR;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        uart_rx_i = 1'b1;
  logic        uart_tx_o;
  logic        host_req_o;
  logic        host_gnt_i = 1'b0;
  logic [31:0] host_addr_o;
  logic        host_we_o;
  logic [3:0]  host_be_o;
  logic [31:0] host_wdata_o;
  logic        host_rvalid_i = 1'b0;
  logic [31:0] host_rdata_i = 32'h0;
  logic        busy_o;
  logic        frame_err_o;

  int total = 0;
  int bad   = 0;

  uart_bus_host #(
    .ClockFrequency(CF), .BaudRate(BR), .AddrWidth(32), .DataWidth(32)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .uart_rx_i(uart_rx_i), .uart_tx_o(uart_tx_o),
    .host_req_o(host_req_o), .host_gnt_i(host_gnt_i), .host_addr_o(host_addr_o),
    .host_we_o(host_we_o), .host_be_o(host_be_o), .host_wdata_o(host_wdata_o),
    .host_rvalid_i(host_rvalid_i), .host_rdata_i(host_rdata_i),
    .busy_o(busy_o), .frame_err_o(frame_err_o)
  );

  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc++;

  // Bus responder: grant after gnt_delay request cycles, answer one cycle after the grant.
  int          gnt_delay = 0, req_wait = 0, n_acc = 0, req_hi = 0, unstable = 0, req_late = 0;
  int          t_rvalid = 0;
  logic [31:0] bus_rdata = 32'h0;
  logic [31:0] s_addr, s_wdata, acc_addr, acc_wdata;
  logic        s_we, acc_we;
  logic [3:0]  acc_be;

  always @(negedge clk_i) begin
    host_rvalid_i = 1'b0;
    if (rst_ni !== 1'b1) begin
      host_gnt_i = 1'b0;
      req_wait   = 0;
    end else if (host_gnt_i) begin
      host_gnt_i = 1'b0;
      if (host_req_o) req_late++;
      host_rvalid_i = 1'b1;
      host_rdata_i  = bus_rdata;
      t_rvalid      = cyc;
    end else if (host_req_o) begin
      req_hi++;
      if (req_wait == 0) begin
        s_addr = host_addr_o; s_we = host_we_o; s_wdata = host_wdata_o;
      end else if (host_addr_o !== s_addr || host_we_o !== s_we || host_wdata_o !== s_wdata) begin
        unstable++;
      end
      if (req_wait >= gnt_delay) begin
        host_gnt_i = 1'b1;
        n_acc++;
        acc_addr = host_addr_o; acc_we = host_we_o; acc_wdata = host_wdata_o; acc_be = host_be_o;
        req_wait = 0;
      end else begin
        req_wait++;
      end
    end
  end

  int fe_cnt = 0;
  always @(negedge clk_i) if (frame_err_o === 1'b1) fe_cnt++;

  int rst_events = 0;
  always @(negedge rst_ni) rst_events++;

  // TX decoder: bytes cut short by a reset are discarded.
  logic [7:0] txq[$];
  int         tx_start[$];
  int         tx_bad_stop = 0;

  initial begin : tx_dec
    logic [7:0] b;
    int r0, ts;
    @(posedge rst_ni);
    forever begin
      @(negedge uart_tx_o);
      r0 = rst_events;
      ts = cyc;
      repeat (CPB / 2) @(negedge clk_i);
      for (int i = 0; i < 8; i++) begin
        repeat (CPB) @(negedge clk_i);
        b[i] = uart_tx_o;
      end
      repeat (CPB) @(negedge clk_i);
      if (r0 == rst_events) begin
        if (uart_tx_o !== 1'b1) tx_bad_stop++;
        txq.push_back(b);
        tx_start.push_back(ts);
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    uart_rx_i = 1'b0;
    repeat (CPB) @(negedge clk_i);
    for (int i = 0; i < 8; i++) begin
      uart_rx_i = b[i];
      repeat (CPB) @(negedge clk_i);
    end
    uart_rx_i = stop_bit;
    repeat (CPB) @(negedge clk_i);
    uart_rx_i = 1'b1;
    if (!stop_bit) repeat (CPB) @(negedge clk_i);
  endtask

  task automatic send_cmd(input logic we, input logic [31:0] addr, input logic [31:0] data);
    send_byte(we ? 8'h57 : 8'h52, 1'b1);
    for (int i = 0; i < 4; i++) send_byte(8'(addr >> (8 * i)), 1'b1);
    if (we) for (int i = 0; i < 4; i++) send_byte(8'(data >> (8 * i)), 1'b1);
  endtask

  task automatic wait_tx(input int n, input int budget, output bit ok);
    int c = 0;
    while (txq.size() < n && c < budget) begin
      @(negedge clk_i);
      c++;
    end
    ok = (txq.size() >= n);
  endtask

  // One full command: expected bus fields and reply bytes come straight from the arguments.
  task automatic do_txn(input string tag, input logic we, input logic [31:0] addr,
                        input logic [31:0] data, input logic [31:0] rdata,
                        input int delay, input bit extra_byte);
    int q0, a0, h0, u0, l0, nb;
    bit ok;
    logic [7:0] exp_b;
    gnt_delay = delay;
    bus_rdata = rdata;
    q0 = txq.size(); a0 = n_acc; h0 = req_hi; u0 = unstable; l0 = req_late;
    send_cmd(we, addr, data);
    if (extra_byte) send_byte(8'h57, 1'b1);
    nb = we ? 1 : 4;
    wait_tx(q0 + nb, 4000, ok);
    chk({tag, "_done"}, 32'(ok), 1);
    chk({tag, "_nacc"}, n_acc - a0, 1);
    chk({tag, "_addr"}, acc_addr, addr);
    chk({tag, "_we"}, 32'(acc_we), 32'(we));
    chk({tag, "_be"}, 32'(acc_be), 32'hF);
    if (we) chk({tag, "_wdata"}, acc_wdata, data);
    chk({tag, "_req_cycles"}, req_hi - h0, delay + 1);
    chk({tag, "_stable"}, unstable - u0, 0);
    chk({tag, "_req_drop"}, req_late - l0, 0);
    for (int i = 0; i < nb; i++) begin
      exp_b = we ? 8'h4B : 8'(rdata >> (8 * i));
      chk({tag, "_txbyte"}, 32'(txq[q0 + i]), 32'(exp_b));
    end
    if (ok) chk({tag, "_tx_after_rvalid"}, 32'(tx_start[q0] > t_rvalid), 1);
    if (ok && !we) chk({tag, "_tx_spacing"}, tx_start[q0 + 3] - tx_start[q0], 3 * 10 * CPB);
    chk({tag, "_busy_end"}, 32'(busy_o), 0);
  endtask

  initial begin : main
    int a0, f0, q0;
    bit ok;
    logic [7:0] junk;
    rst_ni = 1'b0;
    repeat (3) @(negedge clk_i);
    chk("rst_tx", 32'(uart_tx_o), 1);
    chk("rst_req", 32'(host_req_o), 0);
    chk("rst_we", 32'(host_we_o), 0);
    chk("rst_addr", host_addr_o, 0);
    chk("rst_wdata", host_wdata_o, 0);
    chk("rst_be", 32'(host_be_o), 32'hF);
    chk("rst_busy", 32'(busy_o), 0);
    chk("rst_ferr", 32'(frame_err_o), 0);
    rst_ni = 1'b1;
    repeat (5) @(negedge clk_i);

    do_txn("wr", 1'b1, 32'h0000_1000, 32'h0000_0041, 32'h0, 0, 1'b0);
    do_txn("rd", 1'b0, 32'h0000_1008, 32'h0, 32'h0000_0102, 0, 1'b0);
    do_txn("dly", 1'b1, 32'hA5A5_0F0C, 32'hDEAD_BEEF, 32'h0, 5, 1'b0);
    do_txn("drop", 1'b0, 32'h0BAD_F00D, 32'h0, 32'hCAFE_1234, 150, 1'b1);

    // Junk opcode, then a frame with a bad stop bit: no access, one error pulse.
    a0 = n_acc; f0 = fe_cnt; q0 = txq.size();
    send_byte(8'h33, 1'b1);
    send_byte(8'h52, 1'b0);
    repeat (20) @(negedge clk_i);
    chk("bad_fe_pulse", fe_cnt - f0, 1);
    chk("bad_busy", 32'(busy_o), 0);
    chk("bad_nacc", n_acc - a0, 0);
    send_byte(8'h52, 1'b1);
    send_byte(8'h11, 1'b1);
    repeat (5) @(negedge clk_i);
    chk("mid_busy", 32'(busy_o), 1);
    send_byte(8'h22, 1'b0);
    repeat (20) @(negedge clk_i);
    chk("mid_fe_pulse", fe_cnt - f0, 2);
    chk("mid_busy_clr", 32'(busy_o), 0);
    chk("bad_nacc2", n_acc - a0, 0);
    chk("bad_no_tx", txq.size() - q0, 0);
    do_txn("post_bad", 1'b0, 32'h1234_5678, 32'h0, 32'h8765_4321, 1, 1'b0);

    for (int k = 0; k < 6; k++) begin
      junk = 8'($urandom_range(0, 255));
      if (junk == 8'h57 || junk == 8'h52) junk = junk ^ 8'h01;
      if ($urandom_range(0, 1) == 1) send_byte(junk, 1'b1);
      do_txn("rnd", 1'($urandom_range(0, 1)), $urandom, $urandom, $urandom,
             $urandom_range(0, 4), 1'b0);
    end

    // Reset while the second read-response byte is on the line.
    bus_rdata = 32'h4433_2211;
    gnt_delay = 0;
    q0 = txq.size();
    send_cmd(1'b0, 32'h0000_2000, 32'h0);
    wait_tx(q0 + 1, 4000, ok);
    chk("rr_first_done", 32'(ok), 1);
    chk("rr_first_byte", 32'(txq[q0]), 32'h11);
    repeat (30) @(negedge clk_i);
    rst_ni = 1'b0;
    #1;
    chk("rr_tx_in_rst", 32'(uart_tx_o), 1);
    chk("rr_busy_in_rst", 32'(busy_o), 0);
    repeat (3) @(negedge clk_i);
    rst_ni = 1'b1;
    repeat (2) @(negedge clk_i);
    chk("rr_tx_after", 32'(uart_tx_o), 1);
    chk("rr_busy_after", 32'(busy_o), 0);
    chk("rr_req_after", 32'(host_req_o), 0);
    repeat (1200) @(negedge clk_i);
    chk("rr_no_residual", txq.size() - q0, 1);
    do_txn("post_rst", 1'b1, 32'hFEDC_BA98, 32'h0102_0304, 32'h0, 2, 1'b0);

    chk("tx_stop_bits", tx_bad_stop, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_bus_host.md
UART_BUS_HOST -- requirements
Module: uart_bus_host

Interface
REQ-001 SHALL have parameter ClockFrequency, default 50_000_000, system clock in Hz.
REQ-002 SHALL have parameter BaudRate, default 115_200, serial bit rate; ClocksPerBaud = ClockFrequency / BaudRate.
REQ-003 SHALL have parameter AddrWidth, default 32, host bus address width.
REQ-004 SHALL have parameter DataWidth, default 32, host bus data width.
REQ-005 SHALL have port clk_i, input, 1, clock.
REQ-006 SHALL have port rst_ni, input, 1, reset: asynchronous, active-low.
REQ-007 SHALL have port uart_rx_i, input, 1, serial command line (8N1, LSB first, idle high).
REQ-008 SHALL have port uart_tx_o, output, 1, serial response line (8N1, LSB first, idle high).
REQ-009 SHALL have port host_req_o, output, 1, bus request.
REQ-010 SHALL have port host_gnt_i, input, 1, bus grant; request accepted on the cycle req & gnt.
REQ-011 SHALL have port host_addr_o, output, AddrWidth, byte address.
REQ-012 SHALL have port host_we_o, output, 1, write enable.
REQ-013 SHALL have port host_be_o, output, 4, byte enables; always 4'hF.
REQ-014 SHALL have port host_wdata_o, output, DataWidth, write data.
REQ-015 SHALL have port host_rvalid_i, input, 1, response valid, for reads and writes.
REQ-016 SHALL have port host_rdata_i, input, DataWidth, read data, valid with rvalid.
REQ-017 SHALL have port busy_o, output, 1, high whenever the parser is not in IDLE.
REQ-018 SHALL have port frame_err_o, output, 1, one-cycle pulse on a bad stop bit.

Function
REQ-019 RX path SHALL pass uart_rx_i through a 3-flop synchronizer. On a falling edge while RX is idle, it SHALL preload the baud counter to ClocksPerBaud/2 so sampling lands mid-bit.
REQ-020 RX SHALL abandon the frame if the line is high at mid start bit. It SHALL shift 8 data bits, then check the stop bit. Stop=1 gives a one-cycle byte_valid; stop=0 gives a frame_err_o pulse, no byte, and forces the parser to IDLE.
REQ-021 Command frames: 0x57 ('W') + 4 address bytes LE + 4 data bytes LE; 0x52 ('R') + 4 address bytes LE.
REQ-022 Parser states: IDLE, ADDR, DATA, BUS_REQ, BUS_WAIT, RESP.
- IDLE: on 0x57 or 0x52, latch we and go to ADDR; any other byte is discarded and the parser stays in IDLE.
- ADDR: after the 4th byte, go to DATA if we, else BUS_REQ.
- DATA: after the 4th byte, go to BUS_REQ.
- BUS_REQ: assert host_req_o with addr/we/wdata stable; on gnt go to BUS_WAIT; req SHALL drop the cycle after gnt.
- BUS_WAIT: on rvalid, capture rdata and go to RESP.
- RESP: send 0x4B ('K') for a write, or 4 rdata bytes LE for a read; then go to IDLE.
REQ-023 Byte counter SHALL be 2 bits and wrap to 0 after each 4-byte field.
REQ-024 RX bytes arriving in BUS_REQ, BUS_WAIT or RESP SHALL be dropped without error.
REQ-025 host_req_o SHALL assert no earlier than the cycle after the final command byte's byte_valid.
REQ-026 TX SHALL start a byte within 1 cycle of load. Its baud counter SHALL restart at 0 on load, and each bit SHALL last exactly ClocksPerBaud cycles. Response bytes SHALL be back-to-back with a 1-bit stop and no extra idle.
REQ-027 Response bytes SHALL be sent only after host_rvalid_i, never before.

Reset
REQ-028 Reset values: uart_tx_o=1, host_req_o=0, host_we_o=0, host_addr_o=0, host_wdata_o=0, host_be_o=4'hF, busy_o=0, frame_err_o=0; both baud counters 0; parser, RX and TX in IDLE.
REQ-029 Reset asserted mid-frame or mid-bus-transaction SHALL abort everything; after release the block SHALL wait for a fresh start bit.

Structure
REQ-030 A shared package uart_pkg SHALL hold the serial state enum (IDLE/START/PROC/STOP), the opcode constants 0x57/0x52 and the ack constant 0x4B.
REQ-031 The TX serializer SHALL be a sub-module uart_byte_tx (clk/rst, data/valid/ready in, tx out). RX and the parser SHALL stay in this module.

Verification
REQ-032 Verification SHALL cover these directed scenarios at ClockFrequency=1_000_000, BaudRate=100_000:
- Write: RX 57 00 10 00 00 41 00 00 00; gnt immediate, rvalid +1 cycle -> one req: addr 0x1000, we=1, be=F, wdata 0x41; TX 0x4B.
- Read: RX 52 08 10 00 00; rdata 0x00000102 -> req addr 0x1008, we=0; TX 02 01 00 00.
- Delayed gnt: gnt withheld 5 cycles -> req, addr and wdata held stable throughout; exactly one accepted request.
- Bad input: RX 0x33 then a 0x52 frame with stop bit 0 -> no req, one frame_err_o pulse, busy_o=0; the next valid frame executes.
- Reset mid-response: rst_ni low during TX of byte 2 -> uart_tx_o=1 and busy_o=0 immediately after reset; no residual bytes sent.
